// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RISC-V funct3
// access codes and the size decode used by both the store and load paths.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unknown codes fall back to a word access.
    function automatic lsu_size_t size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: size_of = SZ_B;
            F3_H, F3_HU: size_of = SZ_H;
            F3_W:        size_of = SZ_W;
            default:     size_of = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide request/grant/response data-memory port. The LSU is the master,
// the memory (or bus fabric) is the slave.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            MemReq;
    logic            MemWe;
    logic [XLEN-1:0] MemAddr;
    logic [XLEN-1:0] MemWData;
    logic [3:0]      MemBe;
    logic            MemGnt;
    logic            MemRValid;
    logic [XLEN-1:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemBe,
        input  MemGnt, MemRValid, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemBe,
        output MemGnt, MemRValid, MemRData
    );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends
// it according to funct3; word loads pass straight through.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = word[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0000, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns an ALU byte address into an aligned word access
// on the data-memory port, stalling the pipeline until the access completes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ReqValid,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       Funct3,
    input  logic [XLEN-1:0]  ALUResult,
    input  logic [XLEN-1:0]  WriteData,
    output logic             Stall,
    output logic             RespValid,
    output logic [XLEN-1:0]  ReadData,
    output logic             Misaligned,
    load_store_unit_if.master mem
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    lsu_size_t   req_size;
    logic        accept;
    logic        misaligned_in;
    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic [31:0] ext_data;

    assign req_size = size_of(Funct3);
    assign accept   = (state == IDLE) & ReqValid & (MemRead | MemWrite);
    assign Stall    = (state == REQ) | (state == WAIT) | accept;

    always_comb begin
        misaligned_in = ((req_size == SZ_H) & ALUResult[0]) |
                        ((req_size == SZ_W) & (ALUResult[1:0] != 2'b00));
    end

    // Stores replicate the data across lanes so the byte enables alone pick the target.
    always_comb begin
        fmt_wdata = '0;
        fmt_be    = 4'b1111;
        if (MemWrite) begin
            case (req_size)
                SZ_B: begin
                    fmt_wdata = {4{WriteData[7:0]}};
                    fmt_be    = 4'b0001 << ALUResult[1:0];
                end
                SZ_H: begin
                    fmt_wdata = {2{WriteData[15:0]}};
                    fmt_be    = 4'b0011 << ALUResult[1:0];
                end
                default: begin
                    fmt_wdata = WriteData;
                    fmt_be    = 4'b1111;
                end
            endcase
        end
    end

    load_extend u_load_extend (
        .word   (mem.MemRData),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            mem.MemReq   <= 1'b0;
            mem.MemWe    <= 1'b0;
            mem.MemAddr  <= '0;
            mem.MemWData <= '0;
            mem.MemBe    <= '0;
            RespValid    <= 1'b0;
            Misaligned   <= 1'b0;
            ReadData     <= '0;
        end else begin
            RespValid  <= 1'b0;
            Misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q         <= Funct3;
                        off_q        <= ALUResult[1:0];
                        mem.MemWe    <= MemWrite;
                        mem.MemAddr  <= {ALUResult[XLEN-1:2], 2'b00};
                        mem.MemWData <= fmt_wdata;
                        mem.MemBe    <= fmt_be;
                        if (misaligned_in) begin
                            state      <= DONE;
                            RespValid  <= 1'b1;
                            Misaligned <= 1'b1;
                        end else begin
                            state      <= REQ;
                            mem.MemReq <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem.MemGnt) begin
                        mem.MemReq <= 1'b0;
                        if (mem.MemWe) begin
                            state     <= DONE;
                            RespValid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.MemRValid) begin
                        ReadData  <= ext_data;
                        state     <= DONE;
                        RespValid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, misaligned
// rejection, grant/response back-pressure and asynchronous reset mid-access.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic        Stall;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        Misaligned;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int resp_cnt = 0;
    int r0 = 0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .ReqValid   (ReqValid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Funct3     (Funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .Stall      (Stall),
        .RespValid  (RespValid),
        .ReadData   (ReadData),
        .Misaligned (Misaligned),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (RespValid) resp_cnt <= resp_cnt + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        ReqValid  = 1'b1;
        MemWrite  = wr;
        MemRead   = ~wr;
        Funct3    = f3;
        ALUResult = addr;
        WriteData = wd;
        #1;
    endtask

    task automatic idle_in();
        ReqValid = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic do_store(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(1'b1, f3, addr, wd);
        check({nm, "_stall_T"}, Stall, 1);
        tick();
        check({nm, "_req"}, bus.MemReq, 1);
        check({nm, "_we"}, bus.MemWe, 1);
        check({nm, "_addr"}, bus.MemAddr, exp_addr);
        check({nm, "_be"}, bus.MemBe, exp_be);
        check({nm, "_wdata"}, bus.MemWData, exp_wd);
        check({nm, "_stall_T1"}, Stall, 1);
        bus.MemGnt = 1'b1;
        tick();
        bus.MemGnt = 1'b0;
        idle_in();
        check({nm, "_resp"}, RespValid, 1);
        check({nm, "_mis"}, Misaligned, 0);
        check({nm, "_req_drop"}, bus.MemReq, 0);
        check({nm, "_stall_done"}, Stall, 0);
        tick();
        check({nm, "_resp_end"}, RespValid, 0);
    endtask

    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
        issue(1'b0, f3, addr, 32'h0);
        tick();
        check({nm, "_req"}, bus.MemReq, 1);
        check({nm, "_we"}, bus.MemWe, 0);
        check({nm, "_be"}, bus.MemBe, 4'b1111);
        check({nm, "_wdata"}, bus.MemWData, 0);
        check({nm, "_addr"}, bus.MemAddr, exp_addr);
        bus.MemGnt = 1'b1;
        tick();
        bus.MemGnt    = 1'b0;
        bus.MemRValid = 1'b1;
        bus.MemRData  = rdata;
        check({nm, "_stall_wait"}, Stall, 1);
        check({nm, "_resp_early"}, RespValid, 0);
        tick();
        bus.MemRValid = 1'b0;
        idle_in();
        check({nm, "_resp"}, RespValid, 1);
        check({nm, "_rdata"}, ReadData, exp_data);
        check({nm, "_stall_done"}, Stall, 0);
        tick();
    endtask

    initial begin
        bus.MemGnt    = 1'b0;
        bus.MemRValid = 1'b0;
        bus.MemRData  = '0;

        tick();
        check("rst_req", bus.MemReq, 0);
        check("rst_we", bus.MemWe, 0);
        check("rst_resp", RespValid, 0);
        check("rst_mis", Misaligned, 0);
        check("rst_stall", Stall, 0);
        check("rst_rdata", ReadData, 0);
        check("rst_addr", bus.MemAddr, 0);
        check("rst_wdata", bus.MemWData, 0);
        check("rst_be", bus.MemBe, 0);
        reset = 1'b0;
        tick();

        // ReqValid with neither read nor write is ignored
        ReqValid = 1'b1;
        #1;
        check("noop_stall", Stall, 0);
        tick();
        check("noop_req", bus.MemReq, 0);
        check("noop_resp", RespValid, 0);
        idle_in();

        do_store("sw", F3_W, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
        do_store("sb", F3_B, 32'h103, 32'h000000A5, 32'h100, 4'b1000, 32'hA5A5A5A5);
        do_store("sh", F3_H, 32'h102, 32'h1234BEEF, 32'h100, 4'b1100, 32'hBEEFBEEF);

        do_load("lb",   F3_B,  32'h102, 32'h12F45678, 32'h100, 32'hFFFFFFF4);
        do_load("lbu",  F3_BU, 32'h102, 32'h12F45678, 32'h100, 32'h000000F4);
        do_load("lh",   F3_H,  32'h102, 32'h12F45678, 32'h100, 32'h000012F4);
        do_load("lhu0", F3_HU, 32'h100, 32'h12F48678, 32'h100, 32'h00008678);
        do_load("lh0",  F3_H,  32'h100, 32'h12F48678, 32'h100, 32'hFFFF8678);
        do_load("lb1",  F3_B,  32'h105, 32'h00008000, 32'h104, 32'hFFFFFF80);
        do_load("l111", 3'b111, 32'h108, 32'h80000001, 32'h108, 32'h80000001);
        do_load("lw",   F3_W,  32'h10C, 32'h89ABCDEF, 32'h10C, 32'h89ABCDEF);

        // Misaligned word load: one-cycle rejection, memory untouched
        issue(1'b0, F3_W, 32'h101, 32'h0);
        check("mis_lw_stall", Stall, 1);
        tick();
        idle_in();
        check("mis_lw_resp", RespValid, 1);
        check("mis_lw_flag", Misaligned, 1);
        check("mis_lw_req", bus.MemReq, 0);
        check("mis_lw_stall_done", Stall, 0);
        check("mis_lw_rdata_held", ReadData, 32'h89ABCDEF);
        tick();
        check("mis_lw_resp_end", RespValid, 0);
        check("mis_lw_flag_end", Misaligned, 0);
        check("mis_lw_req_end", bus.MemReq, 0);

        // Misaligned halfword store and unknown funct3 treated as word
        issue(1'b1, F3_H, 32'h103, 32'h0000FFFF);
        tick();
        idle_in();
        check("mis_sh_flag", Misaligned, 1);
        check("mis_sh_req", bus.MemReq, 0);
        tick();
        issue(1'b0, 3'b011, 32'h102, 32'h0);
        tick();
        idle_in();
        check("mis_f3_flag", Misaligned, 1);
        check("mis_f3_resp", RespValid, 1);
        tick();

        // Back-pressure: grant late by 3 cycles, read data late by 2 more
        r0 = resp_cnt;
        issue(1'b0, F3_W, 32'h200, 32'h0);
        check("bp_stall_T", Stall, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_req_hold", bus.MemReq, 1);
            check("bp_addr_hold", bus.MemAddr, 32'h200);
            check("bp_be_hold", bus.MemBe, 4'b1111);
            check("bp_stall_req", Stall, 1);
            check("bp_resp_req", RespValid, 0);
            tick();
        end
        check("bp_req_gnt", bus.MemReq, 1);
        check("bp_addr_gnt", bus.MemAddr, 32'h200);
        bus.MemGnt = 1'b1;
        tick();
        bus.MemGnt = 1'b0;
        check("bp_req_after_gnt", bus.MemReq, 0);
        for (int i = 0; i < 2; i++) begin
            check("bp_stall_wait", Stall, 1);
            check("bp_resp_wait", RespValid, 0);
            tick();
        end
        bus.MemRValid = 1'b1;
        bus.MemRData  = 32'hCAFEF00D;
        check("bp_stall_rv", Stall, 1);
        tick();
        bus.MemRValid = 1'b0;
        idle_in();
        check("bp_resp", RespValid, 1);
        check("bp_rdata", ReadData, 32'hCAFEF00D);
        tick();
        check("bp_resp_end", RespValid, 0);
        check("bp_one_pulse", resp_cnt - r0, 1);

        // Reset while waiting for read data; the late response must be ignored
        r0 = resp_cnt;
        issue(1'b0, F3_W, 32'h300, 32'h0);
        tick();
        bus.MemGnt = 1'b1;
        tick();
        bus.MemGnt = 1'b0;
        reset = 1'b1;
        idle_in();
        #1;
        check("rw_req", bus.MemReq, 0);
        check("rw_rdata", ReadData, 0);
        check("rw_stall", Stall, 0);
        check("rw_state", 32'(dut.state), 32'(IDLE));
        tick();
        reset = 1'b0;
        bus.MemRValid = 1'b1;
        bus.MemRData  = 32'h11111111;
        tick();
        bus.MemRValid = 1'b0;
        check("rw_resp_stale", RespValid, 0);
        check("rw_rdata_stale", ReadData, 0);
        tick();
        check("rw_resp_after", RespValid, 0);
        check("rw_no_pulse", resp_cnt - r0, 0);

        // Reset while requesting drops MemReq asynchronously
        issue(1'b1, F3_W, 32'h400, 32'h5555AAAA);
        tick();
        check("rr_req_up", bus.MemReq, 1);
        reset = 1'b1;
        idle_in();
        #1;
        check("rr_req_drop", bus.MemReq, 0);
        check("rr_addr", bus.MemAddr, 0);
        check("rr_be", bus.MemBe, 0);
        tick();
        reset = 1'b0;
        tick();
        check("rr_resp", RespValid, 0);
        check("rr_req_idle", bus.MemReq, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
